// File: rtl/bcd_keypad_entry_ctrl.sv
// bcd_keypad_entry_ctrl: debounces a 10-line one-hot decimal keypad,
// encodes each accepted press to BCD and builds a DIGITS-deep number
// buffer. The buffer is committed downstream over a valid/ready
// handshake. Multi-key presses and overflow raise key_error.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   key_in[9:0]   keypad lines, bit k = key k (already synchronized)
//   enter, clear  single-cycle commit / clear requests
//   buf_digits    live entry buffer, newest digit in [3:0]
//   digit_count   digits currently buffered (0..DIGITS)
//   num_out       committed number, stable while num_valid
//   num_valid     committed number available
//   num_ready     consumer accepts num_out
//   key_error     one-cycle pulse on multi-key press or overflow
module bcd_keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            key_in,
    input  logic                  enter,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   buf_digits,
    output logic [3:0]            digit_count,
    output logic [4*DIGITS-1:0]   num_out,
    output logic                  num_valid,
    input  logic                  num_ready,
    output logic                  key_error
);

    localparam int         W        = 4 * DIGITS;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] CNT_MAX  = 4'(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE
    } state_e;

    state_e         state_q, state_d;
    logic [9:0]     cap_q, cap_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           armed_q, armed_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [3:0]     count_q, count_d;
    logic [W-1:0]   num_q, num_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;

    logic           key_none;
    logic           accept;
    logic           cap_onehot;
    logic [3:0]     digit;
    logic [W-1:0]   digit_w;
    logic           commit;
    logic [W-1:0]   base_buf;
    logic [3:0]     base_cnt;

    assign key_none = (key_in == 10'd0);

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        // A key held through reset must be released before it can be
        // captured; armed tracks whether lines have been seen idle.
        armed_d = armed_q | key_none;

        unique case (state_q)
            IDLE: begin
                if (!key_none && armed_q) begin
                    cap_d   = key_in;
                    cnt_d   = 8'd1;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (key_none) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (key_in != cap_q) begin
                    cap_d = key_in;
                    cnt_d = 8'd1;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    accept  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (key_none) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Key encoding
    // ------------------------------------------------------------------
    assign cap_onehot = (cap_q != 10'd0) &&
                        ((cap_q & (cap_q - 10'd1)) == 10'd0);

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (cap_q[i]) begin
                digit = 4'(i);
            end
        end
    end

    always_comb begin
        digit_w      = '0;
        digit_w[3:0] = digit;
    end

    // ------------------------------------------------------------------
    // Buffer, commit and handshake
    // ------------------------------------------------------------------
    assign commit = enter && !valid_q && (count_q != 4'd0) && !clear;

    // A commit empties the buffer first, so a digit accepted on the
    // same edge lands in a fresh buffer.
    assign base_buf = commit ? '0 : buf_q;
    assign base_cnt = commit ? 4'd0 : count_q;

    always_comb begin
        valid_d = valid_q;
        num_d   = num_q;
        buf_d   = base_buf;
        count_d = base_cnt;
        err_d   = 1'b0;

        if (valid_q && num_ready) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            num_d   = buf_q;
            valid_d = 1'b1;
        end

        if (clear) begin
            buf_d   = '0;
            count_d = 4'd0;
        end else if (accept) begin
            if (!cap_onehot) begin
                err_d = 1'b1;
            end else if (base_cnt < CNT_MAX) begin
                buf_d   = (base_buf << 4) | digit_w;
                count_d = base_cnt + 4'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= 10'd0;
            cnt_q   <= 8'd0;
            armed_q <= key_none;
            buf_q   <= '0;
            count_q <= 4'd0;
            num_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign buf_digits  = buf_q;
    assign digit_count = count_q;
    assign num_out     = num_q;
    assign num_valid   = valid_q;
    assign key_error   = err_q;

endmodule
